// File: rtl/prime_range_scanner_pkg.sv
// Shared calculator constants for the prime range scanner.
// Holds operand width, checker range limit and FSM state encoding.
package prime_range_scanner_pkg;

    // Operand width of the prime checker input.
    localparam int OPERAND_W = 9;

    // Largest value the checker classifies correctly.
    // Trial division stops at 17, so 361 = 19*19 would be misread.
    localparam int PRIME_MAX_N = 359;

    // Width of the prime counter; 72 primes up to 359.
    localparam int PRIME_CNT_W = 7;

    // Scanner FSM state encoding.
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

endpackage

// File: rtl/prime_range_scanner_is_prime.sv
// Combinational prime checker (IsPrimeNumber).
// Ports: number (in, N_W) value to classify; is_prime (out) 1 if prime.
// Valid for number <= PRIME_MAX_N only.
module prime_range_scanner_is_prime
    import prime_range_scanner_pkg::*;
#(
    parameter int N_W = OPERAND_W
) (
    input  logic [N_W-1:0] number,
    output logic           is_prime
);

    // Primes up to floor(sqrt(PRIME_MAX_N)).
    localparam int N_DIV = 7;
    localparam int DIVS [N_DIV] = '{2, 3, 5, 7, 11, 13, 17};

    int n;

    always_comb begin
        n        = int'(number);
        is_prime = (n >= 2);
        for (int i = 0; i < N_DIV; i++) begin
            // A divisor only disqualifies values other than itself.
            if ((n != DIVS[i]) && ((n % DIVS[i]) == 0)) begin
                is_prime = 1'b0;
            end
        end
    end

endmodule

// File: rtl/prime_range_scanner.sv
// Walks an inclusive range [lo, hi] through one prime checker, one value per
// clock, reporting count, first/last prime found and a one-cycle done pulse.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, abort     request a scan / terminate an active scan
//   lo, hi           range bounds, latched on an accepted start
//   busy, done       activity flag / completion pulse
//   err, aborted     range error / abort flags of the last transaction
//   found, count     any prime seen / number of primes seen
//   first_prime      lowest prime seen (0 if none)
//   last_prime       highest prime seen (0 if none)
module prime_range_scanner
    import prime_range_scanner_pkg::*;
#(
    parameter int N_W   = OPERAND_W,
    parameter int MAX_N = PRIME_MAX_N,
    parameter int CNT_W = PRIME_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_W-1:0]   lo,
    input  logic [N_W-1:0]   hi,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             aborted,
    output logic             found,
    output logic [CNT_W-1:0] count,
    output logic [N_W-1:0]   first_prime,
    output logic [N_W-1:0]   last_prime
);

    logic [1:0]       state_q, state_d;
    logic [N_W-1:0]   cur_q, cur_d;
    logic [N_W-1:0]   hi_q, hi_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [N_W-1:0]   first_q, first_d;
    logic [N_W-1:0]   last_q, last_d;
    logic             found_q, found_d;
    logic             err_q, err_d;
    logic             aborted_q, aborted_d;

    logic             cur_is_prime;
    logic             range_bad;

    prime_range_scanner_is_prime #(
        .N_W (N_W)
    ) u_is_prime (
        .number   (cur_q),
        .is_prime (cur_is_prime)
    );

    assign range_bad = (lo > hi) || (hi > N_W'(MAX_N));

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        hi_d      = hi_q;
        count_d   = count_q;
        first_d   = first_q;
        last_d    = last_q;
        found_d   = found_q;
        err_d     = err_q;
        aborted_d = aborted_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d   = '0;
                    first_d   = '0;
                    last_d    = '0;
                    found_d   = 1'b0;
                    aborted_d = 1'b0;
                    hi_d      = hi;
                    cur_d     = lo;
                    err_d     = range_bad;
                    state_d   = range_bad ? S_FINISH : S_SCAN;
                end
            end

            S_SCAN: begin
                if (abort) begin
                    // Abort wins: cur is not evaluated this cycle.
                    aborted_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    if (cur_is_prime) begin
                        count_d = count_q + CNT_W'(1);
                        last_d  = cur_q;
                        if (!found_q) begin
                            first_d = cur_q;
                            found_d = 1'b1;
                        end
                    end
                    // hi <= MAX_N keeps cur+1 from wrapping.
                    if (cur_q == hi_q) begin
                        state_d = S_FINISH;
                    end else begin
                        cur_d = cur_q + N_W'(1);
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            hi_q      <= '0;
            count_q   <= '0;
            first_q   <= '0;
            last_q    <= '0;
            found_q   <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            hi_q      <= hi_d;
            count_q   <= count_d;
            first_q   <= first_d;
            last_q    <= last_d;
            found_q   <= found_d;
            err_q     <= err_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign err         = err_q;
    assign aborted     = aborted_q;
    assign found       = found_q;
    assign count       = count_q;
    assign first_prime = first_q;
    assign last_prime  = last_q;

endmodule

// File: tb/tb_prime_range_scanner.sv
// Scoreboard bench for prime_range_scanner: directed scenarios plus
// randomized ranges checked against a trial-division reference model.
module tb_prime_range_scanner;

    localparam int N_W   = 9;
    localparam int CNT_W = 7;
    localparam int MAXN  = 359;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [N_W-1:0]   lo;
    logic [N_W-1:0]   hi;
    logic             busy;
    logic             done;
    logic             err;
    logic             aborted;
    logic             found;
    logic [CNT_W-1:0] count;
    logic [N_W-1:0]   first_prime;
    logic [N_W-1:0]   last_prime;

    prime_range_scanner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .lo          (lo),
        .hi          (hi),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .aborted     (aborted),
        .found       (found),
        .count       (count),
        .first_prime (first_prime),
        .last_prime  (last_prime)
    );

    typedef struct {
        int acc;
        int lat;
        int cnt;
        int first;
        int last;
        bit found;
        bit err;
        bit ab;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit ref_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Expected outcome of a start with optional abort at cycle ab (0 = none).
    function automatic exp_t model(input int l, input int h, input int ab);
        exp_t e;
        int   n;
        int   neval;
        e.acc = 0; e.cnt = 0; e.first = 0; e.last = 0;
        e.found = 0; e.err = 0; e.ab = 0;
        if (l > h || h > MAXN) begin
            e.err = 1;
            e.lat = 1;
            return e;
        end
        n = h - l + 1;
        if (ab >= 1 && ab <= n) begin
            e.ab  = 1;
            neval = ab - 1;
            e.lat = ab + 1;
        end else begin
            neval = n;
            e.lat = n + 1;
        end
        for (int v = l; v < l + neval; v++) begin
            if (ref_prime(v)) begin
                e.cnt++;
                if (!e.found) e.first = v;
                e.found = 1;
                e.last = v;
            end
        end
        return e;
    endfunction

    // Monitor: counts busy cycles and checks every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", cyc - e.acc, e.lat);
                    chk("busy_cycles", busy_cnt, e.lat);
                    chk("count", int'(count), e.cnt);
                    chk("first_prime", int'(first_prime), e.first);
                    chk("last_prime", int'(last_prime), e.last);
                    chk("found", int'(found), int'(e.found));
                    chk("err", int'(err), int'(e.err));
                    chk("aborted", int'(aborted), int'(e.ab));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_aborted"}, int'(aborted), 0);
        chk({tag, "_found"}, int'(found), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_first"}, int'(first_prime), 0);
        chk({tag, "_last"}, int'(last_prime), 0);
    endtask

    // Issue one start; poke re-asserts start with other bounds at cycle 3.
    task automatic run_txn(input int l, input int h, input int ab,
                           input bit poke);
        exp_t e;
        int   acc;
        @(posedge clk); #1;
        lo    = N_W'(l);
        hi    = N_W'(h);
        start = 1'b1;
        acc   = cyc;
        e     = model(l, h, ab);
        e.acc = acc;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        lo    = N_W'($urandom);
        hi    = N_W'($urandom);
        for (int k = 0; k < 2000 && sb.size() != 0; k++) begin
            abort = (ab > 0 && cyc == acc + ab);
            start = (poke && cyc == acc + 3);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
        chk("txn_completed", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int l;
        int h;
        int ab;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        lo    = '0;
        hi    = '0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle");

        run_txn(2, 20, 0, 0);
        run_txn(24, 28, 0, 0);
        run_txn(0, 359, 0, 0);
        run_txn(50, 40, 0, 0);
        run_txn(0, 400, 0, 0);
        run_txn(7, 7, 0, 0);
        run_txn(2, 100, 5, 0);
        run_txn(2, 20, 0, 0);
        run_txn(2, 60, 0, 1);
        run_txn(359, 359, 0, 0);
        run_txn(360, 360, 0, 0);

        // Reset mid-scan: no done pulse may follow.
        @(posedge clk); #1;
        lo    = N_W'(2);
        hi    = N_W'(100);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midscan_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_txn(2, 20, 0, 0);

        for (int i = 0; i < 40; i++) begin
            l = $urandom_range(0, 370);
            if ($urandom_range(0, 9) == 0) h = $urandom_range(0, 511);
            else h = l + $urandom_range(0, 40);
            if (h > 511) h = 511;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
            run_txn(l, h, ab, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
